// File: rtl/decoder_pkg.sv
// Shared types for the N-to-2^N decoder family.
package decoder_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIRECT = 2'd1,
    S_SCAN   = 2'd2
  } dec_state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/decoder_n_to_2n.sv
// Combinational N-to-2^N one-hot decoder; all zeros when ena is low.
module decoder_n_to_2n #(
  parameter int N = 4
) (
  input  logic            ena,
  input  logic [N-1:0]    in,
  output logic [2**N-1:0] out
);

  always_comb begin
    out = '0;
    for (int i = 0; i < 2**N; i++) begin
      out[i] = ena && (in == N'(i));
    end
  end

endmodule

// File: rtl/decoder_n_to_2n_scan.sv
// Registered one-hot decoder with a dwell timer: DIRECT holds a handshaked index,
// SCAN sweeps every output line and pulses wrap at the end of each sweep.
module decoder_n_to_2n_scan
  import decoder_pkg::*;
#(
  parameter int N           = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic            mode,
  input  logic [N-1:0]    in,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [2**N-1:0] out,
  output logic            out_valid,
  output logic [N-1:0]    index,
  output logic            wrap
);

  localparam int OUT_W = 2**N;
  localparam int DW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(HOLD_CYCLES - 1);
  localparam logic [N-1:0]  IDX_LAST   = '1;

  dec_state_t       state_p1, state_nxt;
  logic [DW-1:0]    dwell_p1, dwell_nxt;
  logic [N-1:0]     index_nxt;
  logic             wrap_nxt;
  logic [OUT_W-1:0] dec_out;
  logic             dwell_end;
  logic             accept;

  assign dwell_end = (dwell_p1 == DWELL_LAST);
  assign in_ready  = ena && (mode == MODE_DIRECT) &&
                     ((state_p1 == S_IDLE) || ((state_p1 == S_DIRECT) && dwell_end));
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_nxt = state_p1;
    dwell_nxt = dwell_p1;
    index_nxt = index;
    if (!ena) begin
      state_nxt = S_IDLE;
      dwell_nxt = '0;
    end else begin
      case (state_p1)
        S_IDLE: begin
          if (accept) begin
            state_nxt = S_DIRECT;
            index_nxt = in;
            dwell_nxt = '0;
          end else if (mode == MODE_SCAN) begin
            state_nxt = S_SCAN;
            index_nxt = '0;
            dwell_nxt = '0;
          end
        end
        S_DIRECT: begin
          if (dwell_end) begin
            dwell_nxt = '0;
            if (accept) index_nxt = in;
            else        state_nxt = S_IDLE;
          end else begin
            dwell_nxt = dwell_p1 + DW'(1);
          end
        end
        S_SCAN: begin
          // A switch back to DIRECT only takes effect once the current dwell ends
          if (dwell_end) begin
            dwell_nxt = '0;
            if (mode == MODE_SCAN) index_nxt = index + N'(1);
            else                   state_nxt = S_IDLE;
          end else begin
            dwell_nxt = dwell_p1 + DW'(1);
          end
        end
        default: begin
          state_nxt = S_IDLE;
          dwell_nxt = '0;
        end
      endcase
    end
  end

  assign wrap_nxt = (state_nxt == S_SCAN) && (index_nxt == IDX_LAST) &&
                    (dwell_nxt == DWELL_LAST);

  // Decode the next index so the registered line appears one cycle after accept
  decoder_n_to_2n #(.N(N)) u_dec (
    .ena (state_nxt != S_IDLE),
    .in  (index_nxt),
    .out (dec_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1  <= S_IDLE;
      dwell_p1  <= '0;
      index     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state_p1  <= state_nxt;
      dwell_p1  <= dwell_nxt;
      index     <= index_nxt;
      out       <= dec_out;
      out_valid <= |dec_out;
      wrap      <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_decoder_n_to_2n_scan.sv
// Scoreboard bench: three decoder configurations share one stimulus stream and are
// compared against a cycle-level reference model of the documented behaviour.
module tb_decoder_n_to_2n_scan;

  typedef struct packed {
    logic [15:0] out;
    logic        vld;
    logic [3:0]  idx;
    logic        wrap;
  } exp_t;

  localparam int NP [3] = '{4, 4, 1};
  localparam int HP [3] = '{4, 2, 1};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       mode = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_v = 4'd0;

  logic [15:0] out0, out1;
  logic [1:0]  out2;
  logic [3:0]  idx0, idx1;
  logic [0:0]  idx2;
  logic        vld0, vld1, vld2, wrap0, wrap1, wrap2, rdy0, rdy1, rdy2;

  logic [15:0] act_out [3];
  logic [3:0]  act_idx [3];
  logic        act_vld [3];
  logic        act_wrap[3];
  logic        act_rdy [3];

  assign act_out[0] = out0;  assign act_out[1] = out1;  assign act_out[2] = {14'd0, out2};
  assign act_idx[0] = idx0;  assign act_idx[1] = idx1;  assign act_idx[2] = {3'd0, idx2};
  assign act_vld[0] = vld0;  assign act_vld[1] = vld1;  assign act_vld[2] = vld2;
  assign act_wrap[0] = wrap0; assign act_wrap[1] = wrap1; assign act_wrap[2] = wrap2;
  assign act_rdy[0] = rdy0;  assign act_rdy[1] = rdy1;  assign act_rdy[2] = rdy2;

  decoder_n_to_2n_scan #(.N(4), .HOLD_CYCLES(4)) u0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .in(in_v), .in_valid(in_valid),
    .in_ready(rdy0), .out(out0), .out_valid(vld0), .index(idx0), .wrap(wrap0));
  decoder_n_to_2n_scan #(.N(4), .HOLD_CYCLES(2)) u1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .in(in_v), .in_valid(in_valid),
    .in_ready(rdy1), .out(out1), .out_valid(vld1), .index(idx1), .wrap(wrap1));
  decoder_n_to_2n_scan #(.N(1), .HOLD_CYCLES(1)) u2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .in(in_v[0:0]), .in_valid(in_valid),
    .in_ready(rdy2), .out(out2), .out_valid(vld2), .index(idx2), .wrap(wrap2));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  // Model state: 0 idle, 1 direct, 2 scan; m_left = cycles still to show after this one
  int   m_st  [3];
  int   m_idx [3];
  int   m_left[3];
  exp_t exp_q [3][$];

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL u%0d %s: got %0h, expected %0h at %0t", k, name, act, exp, $time);
    end
  endtask

  function automatic logic m_ready(input int k);
    return ena && !mode && (m_st[k] == 0 || (m_st[k] == 1 && m_left[k] == 0));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_st[k] = 0; m_idx[k] = 0; m_left[k] = 0;
      exp_q[k].delete();
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int   top;
      logic acc;
      exp_t e;
      top = (1 << NP[k]) - 1;
      acc = m_ready(k) && in_valid;
      if (!ena) m_st[k] = 0;
      else begin
        case (m_st[k])
          0: if (acc) begin
               m_st[k] = 1; m_idx[k] = int'(in_v) & top; m_left[k] = HP[k] - 1;
             end else if (mode) begin
               m_st[k] = 2; m_idx[k] = 0; m_left[k] = HP[k] - 1;
             end
          1: if (m_left[k] == 0) begin
               if (acc) begin m_idx[k] = int'(in_v) & top; m_left[k] = HP[k] - 1; end
               else m_st[k] = 0;
             end else m_left[k]--;
          default: if (m_left[k] == 0) begin
               if (mode) begin m_idx[k] = (m_idx[k] + 1) & top; m_left[k] = HP[k] - 1; end
               else m_st[k] = 0;
             end else m_left[k]--;
        endcase
      end
      e.out  = (m_st[k] != 0) ? 16'(1 << m_idx[k]) : 16'd0;
      e.vld  = (m_st[k] != 0);
      e.idx  = 4'(m_idx[k]);
      e.wrap = (m_st[k] == 2) && (m_idx[k] == top) && (m_left[k] == 0);
      exp_q[k].push_back(e);
    end
  endtask

  task automatic step(input logic e, input logic m, input logic v, input logic [3:0] d);
    @(negedge clk);
    ena = e; mode = m; in_valid = v; in_v = d;
    #1;
    for (int k = 0; k < 3; k++) check("in_ready", k, 32'(act_rdy[k]), 32'(m_ready(k)));
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    ena = 1'b0; in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst out", k, 32'(act_out[k]), 32'd0);
      check("rst out_valid", k, 32'(act_vld[k]), 32'd0);
      check("rst index", k, 32'(act_idx[k]), 32'd0);
      check("rst wrap", k, 32'(act_wrap[k]), 32'd0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: each registered output set is compared after the edge that produced it
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        if (exp_q[k].size() > 0) begin
          exp_t e;
          e = exp_q[k].pop_front();
          check("out", k, 32'(act_out[k]), 32'(e.out));
          check("out_valid", k, 32'(act_vld[k]), 32'(e.vld));
          check("index", k, 32'(act_idx[k]), 32'(e.idx));
          check("wrap", k, 32'(act_wrap[k]), 32'(e.wrap));
          check("onehot0", k, 32'($onehot0(act_out[k])), 32'd1);
        end
      end
    end
  end

  initial begin
    model_reset();
    #3;
    for (int k = 0; k < 3; k++) begin
      check("init out", k, 32'(act_out[k]), 32'd0);
      check("init out_valid", k, 32'(act_vld[k]), 32'd0);
      check("init index", k, 32'(act_idx[k]), 32'd0);
      check("init in_ready ena0", k, 32'(act_rdy[k]), 32'd0);
    end
    ena = 1'b1; mode = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) check("init in_ready", k, 32'(act_rdy[k]), 32'd1);
    ena = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single DIRECT decode, then idle
    step(1, 0, 1, 4'd5);
    repeat (6) step(1, 0, 0, 4'd0);

    // Back-to-back DIRECT with the second index offered on the last dwell cycle
    step(1, 0, 1, 4'd5);
    repeat (3) step(1, 0, 0, 4'd0);
    step(1, 0, 1, 4'd15);
    repeat (6) step(1, 0, 0, 4'd0);

    // Long SCAN covering full sweeps and wrap
    repeat (70) step(1, 1, 0, 4'd0);
    repeat (6) step(1, 0, 0, 4'd0);
    step(0, 0, 0, 4'd0);

    // SCAN then abort around index 7, then restart from index 0
    repeat (30) step(1, 1, 0, 4'd0);
    step(0, 1, 0, 4'd0);
    repeat (6) step(1, 1, 0, 4'd0);

    // Mode change mid-dwell in both directions
    step(0, 0, 0, 4'd0);
    step(1, 0, 1, 4'd3);
    repeat (10) step(1, 1, 0, 4'd0);
    repeat (8) step(1, 0, 1, 4'd6);

    // Async reset in the middle of a DIRECT dwell
    step(1, 0, 1, 4'd9);
    step(1, 0, 0, 4'd0);
    do_reset();

    // Streaming: every cycle offers a new index
    for (int i = 0; i < 12; i++) step(1, 0, 1, 4'($urandom_range(0, 15)));

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      logic m_next;
      m_next = ($urandom_range(0, 19) == 0) ? ~mode : mode;
      step(($urandom_range(0, 31) != 0), m_next, 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)));
    end

    do_reset();
    repeat (5) step(1, 1, 0, 4'd0);
    @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
